// File: rtl/micro_pkg.sv
// Shared types for the multicycle microcoded control store.
package micro_pkg;

  localparam int unsigned UPC_W = 4;
  localparam int unsigned CNT_W = 32;

  // Microstates; encodings 11-15 are unused and treated as illegal.
  typedef enum logic [UPC_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } uState_t;

  // Sequencer select encodings.
  localparam logic [2:0] ACTL_INC   = 3'b000;
  localparam logic [2:0] ACTL_DISP1 = 3'b001;
  localparam logic [2:0] ACTL_DISP2 = 3'b010;
  localparam logic [2:0] ACTL_ZERO  = 3'b011;
  localparam logic [2:0] ACTL_SEVEN = 3'b100;

  // One microinstruction word.
  typedef struct packed {
    logic       legal;
    logic [2:0] addr_ctl;
    logic       mem;
    logic       adr_src;
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       retire;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } uinstr_t;

endpackage

// File: rtl/micro_rom.sv
// Combinational microinstruction ROM indexed by the microprogram counter.
module micro_rom
  import micro_pkg::*;
(
  input  logic [3:0] addr,
  output uinstr_t    ui
);

  // Decode uPC to its microinstruction; unlisted entries stay illegal with all enables off.
  always_comb begin
    ui          = '0;
    ui.addr_ctl = ACTL_ZERO;
    case (uState_t'(addr))
      S_FETCH: begin
        ui.legal = 1'b1; ui.addr_ctl = ACTL_INC; ui.mem = 1'b1; ui.adr_src = 1'b0;
        ui.pc_write = 1'b1; ui.ir_write = 1'b1;
        ui.alu_src_a = 2'b00; ui.alu_src_b = 2'b10; ui.alu_op = 2'b00; ui.result_src = 2'b10;
      end
      S_DECODE: begin
        ui.legal = 1'b1; ui.addr_ctl = ACTL_DISP1;
        ui.alu_src_a = 2'b01; ui.alu_src_b = 2'b01; ui.alu_op = 2'b00;
      end
      S_MEMADR: begin
        ui.legal = 1'b1; ui.addr_ctl = ACTL_DISP2;
        ui.alu_src_a = 2'b10; ui.alu_src_b = 2'b01; ui.alu_op = 2'b00;
      end
      S_MEMREAD: begin
        ui.legal = 1'b1; ui.addr_ctl = ACTL_INC; ui.mem = 1'b1; ui.adr_src = 1'b1;
        ui.result_src = 2'b00;
      end
      S_MEMWB: begin
        ui.legal = 1'b1; ui.addr_ctl = ACTL_ZERO; ui.reg_write = 1'b1; ui.retire = 1'b1;
        ui.result_src = 2'b01;
      end
      S_MEMWRITE: begin
        ui.legal = 1'b1; ui.addr_ctl = ACTL_ZERO; ui.mem = 1'b1; ui.adr_src = 1'b1;
        ui.mem_write = 1'b1; ui.retire = 1'b1; ui.result_src = 2'b00;
      end
      S_EXECR: begin
        ui.legal = 1'b1; ui.addr_ctl = ACTL_INC;
        ui.alu_src_a = 2'b10; ui.alu_src_b = 2'b00; ui.alu_op = 2'b10;
      end
      S_ALUWB: begin
        ui.legal = 1'b1; ui.addr_ctl = ACTL_ZERO; ui.reg_write = 1'b1; ui.retire = 1'b1;
        ui.result_src = 2'b00;
      end
      S_EXECI: begin
        ui.legal = 1'b1; ui.addr_ctl = ACTL_SEVEN;
        ui.alu_src_a = 2'b10; ui.alu_src_b = 2'b01; ui.alu_op = 2'b10;
      end
      S_JAL: begin
        ui.legal = 1'b1; ui.addr_ctl = ACTL_SEVEN; ui.pc_write = 1'b1; ui.reg_write = 1'b1;
        ui.alu_src_a = 2'b01; ui.alu_src_b = 2'b10; ui.alu_op = 2'b00; ui.result_src = 2'b00;
      end
      S_BEQ: begin
        ui.legal = 1'b1; ui.addr_ctl = ACTL_ZERO; ui.branch = 1'b1; ui.retire = 1'b1;
        ui.alu_src_a = 2'b10; ui.alu_src_b = 2'b00; ui.alu_op = 2'b01; ui.result_src = 2'b00;
      end
      default: ui.addr_ctl = ACTL_ZERO;
    endcase
  end

endmodule

// File: rtl/micro_control_store.sv
// Microprogram counter, memory-stall handling and retire counting around the microcode ROM.
module micro_control_store
  import micro_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  nextAddr,
  input  logic        mem_ready,
  output logic [3:0]  currAddr,
  output logic [2:0]  addrCtl,
  output logic        mem_valid,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        Branch,
  output logic        AdrSrc,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        retire,
  output logic [31:0] retired_cnt,
  output logic        illegal
);

  logic [UPC_W-1:0] upc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             illegal_q;
  logic             advance;
  uinstr_t          ui;

  micro_rom u_rom (
    .addr (upc_q),
    .ui   (ui)
  );

  // A memory state only moves on once memory reports completion.
  assign advance = ~ui.mem | mem_ready;

  // Drive the datapath from the current microinstruction; write strobes fire only on the advance cycle.
  always_comb begin
    currAddr    = upc_q;
    addrCtl     = ui.addr_ctl;
    mem_valid   = ui.mem;
    AdrSrc      = ui.adr_src;
    ResultSrc   = ui.result_src;
    ALUSrcA     = ui.alu_src_a;
    ALUSrcB     = ui.alu_src_b;
    ALUOp       = ui.alu_op;
    Branch      = ui.branch;
    PCWrite     = ui.pc_write  & advance;
    IRWrite     = ui.ir_write  & advance;
    MemWrite    = ui.mem_write & advance;
    RegWrite    = ui.reg_write & advance;
    retire      = ui.retire    & advance;
    retired_cnt = cnt_q;
    illegal     = illegal_q | ~ui.legal;
  end

  // uPC, retire counter and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      upc_q     <= UPC_W'(S_FETCH);
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (advance) upc_q <= nextAddr;
      if (advance && ui.retire) cnt_q <= cnt_q + CNT_W'(1);
      if (!ui.legal) illegal_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_micro_control_store.sv
// Directed self-checking bench for micro_control_store with a behavioural sequencer.
module tb_micro_control_store;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  nextAddr;
  logic        mem_ready;
  logic [3:0]  currAddr;
  logic [2:0]  addrCtl;
  logic        mem_valid, PCWrite, IRWrite, MemWrite, RegWrite, Branch, AdrSrc;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic        retire, illegal;
  logic [31:0] retired_cnt;

  // 0 R-type, 1 lw, 2 sw, 3 I-type, 4 jal, 5 beq
  int          op;
  logic        force_en;
  logic [3:0]  force_val;
  int          checks = 0;
  int          failures = 0;

  micro_control_store dut (
    .clk(clk), .reset(reset), .nextAddr(nextAddr), .mem_ready(mem_ready),
    .currAddr(currAddr), .addrCtl(addrCtl), .mem_valid(mem_valid),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .Branch(Branch), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .retire(retire), .retired_cnt(retired_cnt),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Sequencer model: next microaddress from addrCtl, uPC and opcode class.
  always_comb begin
    nextAddr = 4'd0;
    case (addrCtl)
      3'b000: nextAddr = 4'(currAddr + 4'd1);
      3'b001: case (op)
                0: nextAddr = 4'd6;
                1, 2: nextAddr = 4'd2;
                3: nextAddr = 4'd8;
                4: nextAddr = 4'd9;
                default: nextAddr = 4'd10;
              endcase
      3'b010: nextAddr = (op == 2) ? 4'd5 : 4'd3;
      3'b011: nextAddr = 4'd0;
      3'b100: nextAddr = 4'd7;
      default: nextAddr = 4'd0;
    endcase
    if (force_en) nextAddr = force_val;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks for uPC plus the four gated strobes and retire.
  task automatic chk_st(input string tag, input logic [3:0] upc, input logic [4:0] we);
    chk({tag, ".upc"}, 32'(currAddr), 32'(upc));
    chk({tag, ".we"}, 32'({PCWrite, IRWrite, MemWrite, RegWrite, retire}), 32'(we));
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; op = 0; force_en = 1'b0; force_val = 4'd0;
    tick(); tick();
    reset = 1'b0;
    // Fetch presented straight after reset
    chk_st("rst", 4'd0, 5'b11000);
    chk("rst.mem_valid", 32'(mem_valid), 32'd1);
    chk("rst.addrCtl", 32'(addrCtl), 32'd0);
    chk("rst.cnt", retired_cnt, 32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    chk("rst.AdrSrc", 32'(AdrSrc), 32'd0);

    // R-type: 0,1,6,7,0
    tick(); chk_st("r.dec", 4'd1, 5'b00000); chk("r.dec.ctl", 32'(addrCtl), 32'd1);
    tick(); chk_st("r.exe", 4'd6, 5'b00000); chk("r.exe.aluop", 32'(ALUOp), 32'd2);
    tick(); chk_st("r.wb", 4'd7, 5'b00011); chk("r.wb.ctl", 32'(addrCtl), 32'd3);
    tick(); chk_st("r.fetch", 4'd0, 5'b11000); chk("r.cnt", retired_cnt, 32'd1);

    // lw with three stall cycles in MemRead
    op = 1;
    tick(); chk_st("lw.dec", 4'd1, 5'b00000);
    tick(); chk_st("lw.adr", 4'd2, 5'b00000); chk("lw.adr.ctl", 32'(addrCtl), 32'd2);
    tick(); mem_ready = 1'b0;
    chk_st("lw.rd0", 4'd3, 5'b00000);
    chk("lw.rd0.valid", 32'(mem_valid), 32'd1); chk("lw.rd0.adrsrc", 32'(AdrSrc), 32'd1);
    tick(); chk_st("lw.rd1", 4'd3, 5'b00000);
    tick(); chk_st("lw.rd2", 4'd3, 5'b00000);
    mem_ready = 1'b1; #1;
    chk_st("lw.rd3", 4'd3, 5'b00000);
    tick(); chk_st("lw.wb", 4'd4, 5'b00011); chk("lw.wb.rsrc", 32'(ResultSrc), 32'd1);
    tick(); chk_st("lw.fetch", 4'd0, 5'b11000); chk("lw.cnt", retired_cnt, 32'd2);

    // sw: 0,1,2,5,0 with one stall cycle in MemWrite
    op = 2;
    tick(); tick(); chk_st("sw.adr", 4'd2, 5'b00000);
    tick(); mem_ready = 1'b0; #1;
    chk_st("sw.wr.stall", 4'd5, 5'b00000); chk("sw.wr.valid", 32'(mem_valid), 32'd1);
    mem_ready = 1'b1; #1;
    chk_st("sw.wr.go", 4'd5, 5'b00101);
    tick(); chk_st("sw.fetch", 4'd0, 5'b11000); chk("sw.cnt", retired_cnt, 32'd3);

    // jal: 0,1,9,7,0
    op = 4;
    tick(); tick(); chk_st("jal", 4'd9, 5'b10010); chk("jal.ctl", 32'(addrCtl), 32'd4);
    tick(); chk_st("jal.wb", 4'd7, 5'b00011);
    tick(); chk("jal.cnt", retired_cnt, 32'd4);

    // Forced jump to illegal uPC 12 from Decode
    op = 0;
    tick(); chk_st("ill.dec", 4'd1, 5'b00000);
    force_en = 1'b1; force_val = 4'd12;
    tick(); force_en = 1'b0; #1;
    chk_st("ill.st", 4'd12, 5'b00000);
    chk("ill.valid", 32'(mem_valid), 32'd0); chk("ill.ctl", 32'(addrCtl), 32'd3);
    chk("ill.flag", 32'(illegal), 32'd1);
    tick(); chk_st("ill.fetch", 4'd0, 5'b11000); chk("ill.sticky0", 32'(illegal), 32'd1);
    tick(); chk("ill.sticky1", 32'(illegal), 32'd1); chk("ill.cnt", retired_cnt, 32'd4);

    // Reset during a Fetch stall (uPC now 1: run R-type back to Fetch)
    tick(); tick(); tick(); chk_st("rs.fetch", 4'd0, 5'b11000); chk("rs.cnt5", retired_cnt, 32'd5);
    mem_ready = 1'b0; #1;
    chk_st("rs.stall", 4'd0, 5'b00000);
    tick(); chk_st("rs.stall2", 4'd0, 5'b00000);
    reset = 1'b1;
    tick(); reset = 1'b0; mem_ready = 1'b1; #1;
    chk_st("rs.after", 4'd0, 5'b11000);
    chk("rs.cnt", retired_cnt, 32'd0); chk("rs.illegal", 32'(illegal), 32'd0);
    chk("rs.valid", 32'(mem_valid), 32'd1);

    // Counter wrap on a BEQ retire
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    #1 chk("wrap.pre", retired_cnt, 32'hFFFF_FFFF);
    op = 5;
    tick(); tick(); chk_st("beq", 4'd10, 5'b00001);
    chk("beq.branch", 32'(Branch), 32'd1); chk("beq.aluop", 32'(ALUOp), 32'd1);
    tick(); chk_st("beq.fetch", 4'd0, 5'b11000); chk("wrap.cnt", retired_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
